// File: rtl/gcd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : gcd_arbiter
// Brief    : Round-robin sharing of one GCD engine among N_REQ requesters,
//            with local zero-operand resolution and a transaction watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module gcd_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [N_REQ-1:0]       req_i,
    input  logic [N_REQ*WIDTH-1:0] a_i,
    input  logic [N_REQ*WIDTH-1:0] b_i,
    output logic [N_REQ-1:0]       gnt_o,
    output logic [N_REQ-1:0]       done_o,
    output logic [WIDTH-1:0]       result_o,
    output logic                   err_o,
    output logic                   core_req_o,
    output logic [WIDTH-1:0]       core_a_o,
    output logic [WIDTH-1:0]       core_b_o,
    input  logic                   core_busy_i,
    input  logic                   core_valid_i,
    input  logic [WIDTH-1:0]       core_result_i
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] C_TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [PTR_W-1:0] C_PTR_LAST = PTR_W'(N_REQ - 1);
    localparam logic [PTR_W:0]   C_N_REQ    = (PTR_W + 1)'(N_REQ);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             r_state,    w_state_nxt;
    logic [PTR_W-1:0]   r_rr_ptr,   w_rr_nxt;
    logic [PTR_W-1:0]   r_owner,    w_owner_nxt;
    logic [TMR_W-1:0]   r_timer,    w_timer_nxt;
    logic [N_REQ-1:0]   r_gnt,      w_gnt_nxt;
    logic [N_REQ-1:0]   r_done,     w_done_nxt;
    logic [WIDTH-1:0]   r_result,   w_result_nxt;
    logic               r_err,      w_err_nxt;
    logic               r_core_req, w_core_req_nxt;
    logic [WIDTH-1:0]   r_core_a,   w_core_a_nxt;
    logic [WIDTH-1:0]   r_core_b,   w_core_b_nxt;

    logic               w_found;
    logic [PTR_W-1:0]   w_winner;
    logic [PTR_W:0]     w_idx;
    logic [N_REQ-1:0]   w_win_onehot;
    logic [N_REQ-1:0]   w_own_onehot;
    logic [WIDTH-1:0]   w_sel_a;
    logic [WIDTH-1:0]   w_sel_b;

    // Scan upward from the round-robin pointer, wrapping at N_REQ.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_idx = {1'b0, r_rr_ptr} + (PTR_W + 1)'(i);
            if (w_idx >= C_N_REQ) begin
                w_idx = w_idx - C_N_REQ;
            end
            if (!w_found && req_i[w_idx[PTR_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[PTR_W-1:0];
            end
        end
    end

    assign w_win_onehot = N_REQ'(1) << w_winner;
    assign w_own_onehot = N_REQ'(1) << r_owner;
    assign w_sel_a      = a_i[w_winner*WIDTH +: WIDTH];
    assign w_sel_b      = b_i[w_winner*WIDTH +: WIDTH];

    always_comb begin
        w_state_nxt    = r_state;
        w_rr_nxt       = r_rr_ptr;
        w_owner_nxt    = r_owner;
        w_timer_nxt    = r_timer;
        w_gnt_nxt      = '0;
        w_done_nxt     = '0;
        w_result_nxt   = '0;
        w_err_nxt      = 1'b0;
        w_core_req_nxt = 1'b0;
        w_core_a_nxt   = '0;
        w_core_b_nxt   = '0;

        case (r_state)
            ST_IDLE: begin
                // A busy engine here is leftover activity from before reset.
                if (w_found && !core_busy_i) begin
                    w_owner_nxt = w_winner;
                    w_gnt_nxt   = w_win_onehot;
                    w_timer_nxt = '0;
                    if ((w_sel_a != '0) && (w_sel_b != '0)) begin
                        w_state_nxt    = ST_ISSUE;
                        w_core_req_nxt = 1'b1;
                        w_core_a_nxt   = w_sel_a;
                        w_core_b_nxt   = w_sel_b;
                    end else begin
                        w_state_nxt  = ST_DONE;
                        w_done_nxt   = w_win_onehot;
                        w_result_nxt = (w_sel_a == '0) ? w_sel_b : w_sel_a;
                    end
                end
            end

            ST_ISSUE: begin
                w_timer_nxt = r_timer + TMR_W'(1);
                if (core_busy_i) begin
                    w_state_nxt = ST_WAIT;
                end else if (r_timer >= C_TMR_LAST) begin
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = w_own_onehot;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_core_req_nxt = 1'b1;
                    w_core_a_nxt   = r_core_a;
                    w_core_b_nxt   = r_core_b;
                end
            end

            ST_WAIT: begin
                w_timer_nxt = r_timer + TMR_W'(1);
                if (core_valid_i) begin
                    w_state_nxt  = ST_DONE;
                    w_done_nxt   = w_own_onehot;
                    w_result_nxt = core_result_i;
                end else if (r_timer >= C_TMR_LAST) begin
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = w_own_onehot;
                    w_err_nxt   = 1'b1;
                end
            end

            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_rr_nxt    = (r_owner == C_PTR_LAST) ? '0 : r_owner + PTR_W'(1);
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= '0;
            r_owner    <= '0;
            r_timer    <= '0;
            r_gnt      <= '0;
            r_done     <= '0;
            r_result   <= '0;
            r_err      <= 1'b0;
            r_core_req <= 1'b0;
            r_core_a   <= '0;
            r_core_b   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_owner    <= w_owner_nxt;
            r_timer    <= w_timer_nxt;
            r_gnt      <= w_gnt_nxt;
            r_done     <= w_done_nxt;
            r_result   <= w_result_nxt;
            r_err      <= w_err_nxt;
            r_core_req <= w_core_req_nxt;
            r_core_a   <= w_core_a_nxt;
            r_core_b   <= w_core_b_nxt;
        end
    end

    assign gnt_o      = r_gnt;
    assign done_o     = r_done;
    assign result_o   = r_result;
    assign err_o      = r_err;
    assign core_req_o = r_core_req;
    assign core_a_o   = r_core_a;
    assign core_b_o   = r_core_b;

endmodule
`default_nettype wire
